// File: rtl/alu_pkg.sv
// Shared decode constants and types for the handshaked RV32/64 IM ALU.
// Base and M-extension funct3 codes, the M-extension funct7 and FSM/op-kind enums.
package alu_pkg;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_t;

    typedef enum logic [1:0] {
        OP_BASE = 2'd0,
        OP_MUL  = 2'd1,
        OP_DIV  = 2'd2
    } op_kind_t;

endpackage

// File: rtl/alu_m_iter.sv
// Iterative unsigned engine: XLEN-step shift-add multiply or restoring divide.
// Operates on magnitudes only; the parent applies sign correction on the last step.
module alu_m_iter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kill,
    input  logic                start,
    input  logic                is_div,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    output logic                done,
    output logic [2*XLEN-1:0]   acc_next
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(XLEN - 1);

    // acc: multiply = {partial sum, remaining multiplier}; divide = {remainder, quotient}
    logic                div_mode;
    logic                busy;
    logic [SHW-1:0]      cnt;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_shift;
    logic [XLEN:0]       rem_diff;

    // NOTE: every always_comb output gets a value on every path, else a latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_shift = acc[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, opnd};
        if (!div_mode) begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end else if (rem_diff[XLEN]) begin
            acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    assign done = busy && (cnt == LAST_ITER);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
        end else if (kill) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            div_mode <= is_div;
            opnd     <= op_b;
            acc      <= {{XLEN{1'b0}}, op_a};
        end else if (busy) begin
            acc <= acc_next;
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_m.sv
// Execute-stage RV IM ALU with valid/ready on both sides.
// Base ops and divide special cases finish in one cycle; mul/div take XLEN iterations.
module alu_m
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             op_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t        state;
    op_kind_t          kind;
    logic [2:0]        m_f3;
    logic              neg_res;

    logic              accept;
    logic              it_start;
    logic              it_done;
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              neg_sel;
    logic              div_special;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   base_res;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   div_pick;
    logic [XLEN-1:0]   iter_res;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = b[SHW-1:0];

    always_comb begin
        kind = OP_BASE;
        if (!op_imm && (funct7 == F7_MULDIV)) begin
            kind = funct3[2] ? OP_DIV : OP_MUL;
        end
    end

    always_comb begin
        base_res = '0;
        case (funct3)
            F3_ADD:  base_res = (!op_imm && funct7[5]) ? a - b : a + b;
            F3_SLL:  base_res = a << shamt;
            F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            F3_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
            F3_XOR:  base_res = a ^ b;
            F3_SR:   base_res = funct7[5] ? XLEN'($signed(a) >>> shamt) : a >> shamt;
            F3_OR:   base_res = a | b;
            F3_AND:  base_res = a & b;
            default: base_res = '0;
        endcase
    end

    // Signedness per M-op; the engine only ever sees magnitudes.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
            F3_MULHSU: a_signed = 1'b1;
            F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            default: ;
        endcase
    end

    assign a_neg   = a_signed && a[XLEN-1];
    assign b_neg   = b_signed && b[XLEN-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign neg_sel = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

    always_comb begin
        div_special = 1'b0;
        special_res = '0;
        if (b == '0) begin
            div_special = 1'b1;
            special_res = funct3[1] ? a : '1;
        end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (a == XLEN_MIN) && (b == '1)) begin
            div_special = 1'b1;
            special_res = funct3[1] ? '0 : a;
        end
    end

    // kill discards a same-cycle accept, so the engine must not start either.
    assign it_start = accept && !kill &&
                      ((kind == OP_MUL) || ((kind == OP_DIV) && !div_special));

    alu_m_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .kill     (kill),
        .start    (it_start),
        .is_div   (kind == OP_DIV),
        .op_a     (a_mag),
        .op_b     (b_mag),
        .done     (it_done),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix = neg_res ? -acc_next : acc_next;
        div_pick = m_f3[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        if (m_f3[2]) begin
            iter_res = neg_res ? -div_pick : div_pick;
        end else if (m_f3 == F3_MUL) begin
            iter_res = prod_fix[XLEN-1:0];
        end else begin
            iter_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            m_f3    <= '0;
            neg_res <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
        end else if (accept) begin
            m_f3    <= funct3;
            neg_res <= neg_sel;
            case (kind)
                OP_MUL: state <= MUL;
                OP_DIV: begin
                    if (div_special) begin
                        result <= special_res;
                        state  <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                default: begin
                    result <= base_res;
                    state  <= DONE;
                end
            endcase
        end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
        end else if (((state == MUL) || (state == DIV)) && it_done) begin
            result <= iter_res;
            state  <= DONE;
        end
    end

endmodule

// File: doc/alu_m.md
Name: alu_m

Overview:
- Parametrised, handshaked successor to the single-cycle RV32I ALU.
- Executes all RV base integer ALU ops plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for XLEN-bit operands.
- Base ops complete in 1 cycle; multiply and divide use an iterative shift-add / restoring-divide engine.
- Sits in the execute stage; valid/ready on both sides lets the pipeline stall on long ops.

Parameters:
- XLEN, 32, operand/result width. Legal values: 32 or 64.
- SHW, $clog2(XLEN), shift-amount width. Derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- kill  in  1  synchronous abort of any in-flight or held op.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- a  in  XLEN  operand rs1.
- b  in  XLEN  operand rs2 or immediate.
- funct3  in  3  RV funct3.
- funct7  in  7  RV funct7.
- op_imm  in  1  OP-IMM form: funct7 ignored for funct3=000 and M-ext selection.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, iteration counter=0, in_ready=1 once reset is released.
- Accept: in_valid & in_ready at a rising edge. Fire: out_valid & out_ready.
- M-ext selection: op_imm=0 & funct7=7'b0000001. Otherwise base ops are selected by funct3:
  - 000: ADD, or SUB when !op_imm & funct7[5].
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 110: OR. 111: AND.
  - 101: SRL when funct7[5]=0, SRA when funct7[5]=1 (regardless of op_imm).
  - Shift amount = b[SHW-1:0]. SLT/SLTU zero-extend the 1-bit result.
- States:
  - IDLE: in_ready=1.
  - MUL, DIV: in_ready=0.
  - DONE: out_valid=1; result held stable until fire.
- Transitions:
  - IDLE + accept of a base op -> DONE; result registered at the accept edge (1-cycle latency).
  - IDLE + accept of a mul op -> MUL.
  - IDLE + accept of a div/rem op -> DIV, unless a special case applies, then -> DONE directly.
  - MUL/DIV: one iteration per cycle for XLEN cycles; the final sign correction is applied at the last iteration edge -> DONE. out_valid rises exactly XLEN+1 cycles after the accept edge.
  - DONE + fire -> IDLE.
- Back-to-back: in_ready = IDLE | (DONE & out_ready). Simultaneous fire and accept is legal and follows the IDLE+accept rules in the same edge. Base ops can therefore sustain 1 op/cycle.
- Multiply arithmetic:
  - Operands converted to magnitudes: a signed for MULH/MULHSU; b signed for MULH only.
  - 2*XLEN unsigned product; negated if operand signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide arithmetic:
  - Restoring divide on magnitudes (signed for DIV/REM).
  - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
- Divide special cases (resolved at accept, 1-cycle latency):
  - b=0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a = most negative, b = -1): DIV -> a; REM -> 0.
- kill=1 at an edge: state -> IDLE, out_valid=0, counter cleared; any accept in the same cycle is discarded. kill has priority over all else.
- rst_n assertion mid-op: immediate return to reset values; no partial result ever becomes visible.
- in_valid while busy: ignored. The requester must hold the request until accepted.

Decomposition:
- Package alu_pkg holds:
  - funct3 localparams for base and M-ext ops.
  - F7_MULDIV=7'b0000001.
  - Typedef enum alu_state_t {IDLE, MUL, DIV, DONE}.
  - Typedef op_kind_t (BASE/MUL/DIV).
- One sub-module, alu_m_iter: the XLEN-cycle shift-add / restoring-divide datapath with start/done, operating on magnitudes.
- Combinational base ops, sign handling and the FSM stay in alu_m.

Test Plan:
- ADD a=5, b=7, then SUB a=5, b=7 (funct7=0x20) back-to-back with out_ready=1 -> results 12 then 0xFFFFFFFE, each out_valid 1 cycle after accept; in_ready stays 1.
- SRA a=0x80000000, b=4, funct7=0x20, op_imm=1 -> 0xF8000000. SRL same operands, funct7=0 -> 0x08000000.
- MULH and MULHU with a=b=0xFFFFFFFF -> 0x00000000 and 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF. DIVU a=100, b=0 -> 0xFFFFFFFF in 1 cycle. DIV a=0x80000000, b=-1 -> 0x80000000 in 1 cycle.
- Backpressure: XOR result with out_ready held 0 for 3 cycles -> result and out_valid stable, in_ready=0; on release, fire plus new accept in the same cycle.
- kill asserted 10 cycles into a DIVU -> IDLE next edge, out_valid never rises. Repeat with rst_n pulse mid-MUL -> all outputs at reset values asynchronously.
